// File: rtl/uart_tx_arbiter_if.sv
// Requester/PHY bundle of the UART TX arbiter; slave is the arbiter's view, master the environment's.
interface uart_tx_arbiter_if;
  logic         tx_enable_in;
  logic [127:0] req_data1_in;
  logic [127:0] req_data2_in;
  logic [3:0]   req_valid_in;
  logic [3:0]   req_ready_out;
  logic [31:0]  tx_data1_out;
  logic [31:0]  tx_data2_out;
  logic         tx_valid_out;
  logic         tx_ready_in;
  logic [1:0]   tx_src_id_out;
  logic         tx_timeout_out;
  logic [15:0]  sent_cnt_out;

  modport slave (
    input  tx_enable_in, req_data1_in, req_data2_in, req_valid_in, tx_ready_in,
    output req_ready_out, tx_data1_out, tx_data2_out, tx_valid_out,
           tx_src_id_out, tx_timeout_out, sent_cnt_out
  );

  modport master (
    output tx_enable_in, req_data1_in, req_data2_in, req_valid_in, tx_ready_in,
    input  req_ready_out, tx_data1_out, tx_data2_out, tx_valid_out,
           tx_src_id_out, tx_timeout_out, sent_cnt_out
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter of 4 requesters onto one UART PHY; grant is combinational, frame presented next cycle.
// Backpressure: frame held until tx_ready_in, or dropped with a timeout pulse after TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int REQ_NUM     = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W  = $clog2(REQ_NUM);
  localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, win_idx, cand, src_id;
  logic              win_found, grant, done, drop;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       hold1, hold2;
  logic              tmo;
  logic [15:0]       sent_cnt;

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      cand = rr_ptr + IDX_W'(k);
      if (bus.req_valid_in[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (reset_n && bus.tx_enable_in && win_found) begin
          grant     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready_in) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      src_id   <= '0;
      hold1    <= '0;
      hold2    <= '0;
      wait_cnt <= '0;
      tmo      <= 1'b0;
      sent_cnt <= '0;
    end else begin
      tmo <= drop;
      if (grant) begin
        hold1    <= bus.req_data1_in[{win_idx, 5'd0} +: 32];
        hold2    <= bus.req_data2_in[{win_idx, 5'd0} +: 32];
        src_id   <= win_idx;
        wait_cnt <= '0;
      end else if (state == SEND && !bus.tx_ready_in) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (done) sent_cnt <= sent_cnt + 16'd1;
      // Both completion and drop rotate priority past the owner of the frame.
      if (done || drop) rr_ptr <= src_id + IDX_W'(1);
    end
  end

  assign bus.req_ready_out  = grant ? (REQ_NUM'(1) << win_idx) : '0;
  assign bus.tx_valid_out   = (state == SEND);
  assign bus.tx_data1_out   = hold1;
  assign bus.tx_data2_out   = hold2;
  assign bus.tx_src_id_out  = src_id;
  assign bus.tx_timeout_out = tmo;
  assign bus.sent_cnt_out   = sent_cnt;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance a uses the default timeout, instance b a 16-cycle timeout.
module tb_uart_tx_arbiter;
  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests   = 0;
  int   fails   = 0;
  logic [3:0] seen;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if a ();
  uart_tx_arbiter_if b ();

  uart_tx_arbiter dut_a (.sys_clk(sys_clk), .reset_n(reset_n), .bus(a));
  uart_tx_arbiter #(.TIMEOUT_CYC(16)) dut_b (.sys_clk(sys_clk), .reset_n(reset_n), .bus(b));

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    a.tx_enable_in = 0; a.tx_ready_in = 0; a.req_valid_in = 0;
    a.req_data1_in = '0; a.req_data2_in = '0;
    b.tx_enable_in = 0; b.tx_ready_in = 0; b.req_valid_in = 0;
    b.req_data1_in = '0; b.req_data2_in = '0;
    tick(); tick();
    chk("rst_valid", 32'(a.tx_valid_out), 0);
    chk("rst_ready", 32'(a.req_ready_out), 0);
    chk("rst_d1", a.tx_data1_out, 0);
    chk("rst_src", 32'(a.tx_src_id_out), 0);
    chk("rst_sent", 32'(a.sent_cnt_out), 0);
    chk("rst_tmo", 32'(a.tx_timeout_out), 0);
    reset_n = 1'b1;
    tick();

    // Single requester 1, PHY ready.
    a.tx_enable_in = 1; a.tx_ready_in = 1;
    a.req_data1_in[63:32] = 32'h12345678;
    a.req_data2_in[63:32] = 32'h9ABCDEF0;
    a.req_valid_in = 4'b0010;
    #1; chk("t1_ready", 32'(a.req_ready_out), 32'h2);
    tick(); a.req_valid_in = 0; #1;
    chk("t1_valid", 32'(a.tx_valid_out), 1);
    chk("t1_d1", a.tx_data1_out, 32'h12345678);
    chk("t1_d2", a.tx_data2_out, 32'h9ABCDEF0);
    chk("t1_src", 32'(a.tx_src_id_out), 1);
    chk("t1_ready_send", 32'(a.req_ready_out), 0);
    tick(); #1;
    chk("t1_idle", 32'(a.tx_valid_out), 0);
    chk("t1_sent", 32'(a.sent_cnt_out), 1);
    chk("t1_hold", a.tx_data1_out, 32'h12345678);

    // All four valid, PHY always ready: 0,1,2,3,0 two cycles apart.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a.req_data1_in[32*i +: 32] = 32'hA0000000 + i;
      a.req_data2_in[32*i +: 32] = 32'hB0000000 + i;
    end
    a.req_valid_in = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1; chk("rr_ready", 32'(a.req_ready_out), 32'(1) << (g % 4));
      tick(); #1;
      chk("rr_src", 32'(a.tx_src_id_out), g % 4);
      chk("rr_d1", a.tx_data1_out, 32'hA0000000 + (g % 4));
      chk("rr_valid", 32'(a.tx_valid_out), 1);
      chk("rr_no_grant", 32'(a.req_ready_out), 0);
      tick();
    end
    a.req_valid_in = 0; #1;
    chk("rr_sent", 32'(a.sent_cnt_out), 5);

    // Requester 2 with PHY stalled 50 cycles.
    a.tx_ready_in = 0;
    a.req_data1_in[95:64] = 32'hCAFE0002;
    a.req_data2_in[95:64] = 32'hBEEF0002;
    a.req_valid_in = 4'b0100;
    #1; chk("w_ready", 32'(a.req_ready_out), 32'h4);
    tick(); a.req_valid_in = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("w_d1", a.tx_data1_out, 32'hCAFE0002);
      chk("w_vld_tmo", 32'({a.tx_valid_out, a.tx_timeout_out}), 32'h2);
      tick();
    end
    a.tx_ready_in = 1; #1;
    chk("w_last_d2", a.tx_data2_out, 32'hBEEF0002);
    chk("w_last_vld", 32'(a.tx_valid_out), 1);
    tick(); #1;
    chk("w_done_vld", 32'(a.tx_valid_out), 0);
    chk("w_sent", 32'(a.sent_cnt_out), 6);
    chk("w_tmo", 32'(a.tx_timeout_out), 0);
    tick(); #1;
    chk("w_no_extra", 32'(a.sent_cnt_out), 6);

    // Grants blocked while disabled; in-flight frame still completes.
    a.tx_enable_in = 0; a.tx_ready_in = 0; a.req_valid_in = 4'b0001;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      #1; seen = seen | a.req_ready_out | {3'b0, a.tx_valid_out};
      tick();
    end
    chk("dis_ready", 32'(seen), 0);
    a.tx_enable_in = 1; #1;
    chk("en_ready", 32'(a.req_ready_out), 32'h1);
    tick(); a.req_valid_in = 0; a.tx_enable_in = 0; a.tx_ready_in = 1; #1;
    chk("en_src", 32'(a.tx_src_id_out), 0);
    chk("en_valid", 32'(a.tx_valid_out), 1);
    tick(); #1;
    chk("en_sent", 32'(a.sent_cnt_out), 7);
    chk("en_valid_off", 32'(a.tx_valid_out), 0);

    // Timeout on instance b: requester 3, PHY never ready.
    b.tx_enable_in = 1; b.tx_ready_in = 0;
    b.req_data1_in[127:96] = 32'h33333333;
    b.req_valid_in = 4'b1000;
    #1; chk("to_ready", 32'(b.req_ready_out), 32'h8);
    tick(); b.req_valid_in = 0;
    for (int c = 0; c < 16; c++) begin
      #1; chk("to_vld_tmo", 32'({b.tx_valid_out, b.tx_timeout_out}), 32'h2);
      tick();
    end
    #1;
    chk("to_pulse", 32'(b.tx_timeout_out), 1);
    chk("to_valid", 32'(b.tx_valid_out), 0);
    chk("to_sent", 32'(b.sent_cnt_out), 0);
    b.req_valid_in = 4'b1001; #1;
    chk("to_next_ready", 32'(b.req_ready_out), 32'h1);
    tick(); b.req_valid_in = 0; b.tx_ready_in = 1; #1;
    chk("to_pulse_end", 32'(b.tx_timeout_out), 0);
    chk("to_src", 32'(b.tx_src_id_out), 0);
    tick(); #1;
    chk("to_sent_after", 32'(b.sent_cnt_out), 1);

    // Ready arrives in the would-be timeout cycle: completion wins.
    b.tx_ready_in = 0; b.req_valid_in = 4'b0010; #1;
    chk("tie_ready", 32'(b.req_ready_out), 32'h2);
    tick(); b.req_valid_in = 0;
    repeat (15) tick();
    b.tx_ready_in = 1; #1;
    chk("tie_valid", 32'(b.tx_valid_out), 1);
    tick(); #1;
    chk("tie_tmo", 32'(b.tx_timeout_out), 0);
    chk("tie_sent", 32'(b.sent_cnt_out), 2);
    chk("tie_valid_off", 32'(b.tx_valid_out), 0);
    tick(); #1;
    chk("tie_tmo_late", 32'(b.tx_timeout_out), 0);

    // Reset asserted mid-SEND on instance a.
    a.tx_enable_in = 1; a.tx_ready_in = 0; a.req_valid_in = 4'b0100;
    tick(); #1;
    chk("mr_pre_valid", 32'(a.tx_valid_out), 1);
    chk("mr_pre_src", 32'(a.tx_src_id_out), 2);
    reset_n = 1'b0; #1;
    chk("mr_valid", 32'(a.tx_valid_out), 0);
    chk("mr_ready", 32'(a.req_ready_out), 0);
    chk("mr_d1", a.tx_data1_out, 0);
    chk("mr_d2", a.tx_data2_out, 0);
    chk("mr_src", 32'(a.tx_src_id_out), 0);
    chk("mr_sent", 32'(a.sent_cnt_out), 0);
    chk("mr_tmo", 32'(a.tx_timeout_out), 0);
    tick(); a.req_valid_in = 0; a.tx_ready_in = 1; reset_n = 1'b1;
    tick(); tick(); #1;
    chk("mr_no_xfer", 32'(a.sent_cnt_out), 0);
    chk("mr_no_valid", 32'(a.tx_valid_out), 0);
    chk("mr_no_tmo", 32'(a.tx_timeout_out), 0);
    a.req_valid_in = 4'b1001; #1;
    chk("mr_first_grant", 32'(a.req_ready_out), 32'h1);
    tick(); a.req_valid_in = 0;
    tick(); #1;
    chk("mr_sent_after", 32'(a.sent_cnt_out), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
